// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates the CPU instruction port (imem_*) and data port (dmem_*) onto
//   a single downstream L2 port (l2_*). Each serviced request gets exactly one
//   single-cycle *_resp pulse carrying the read data (0 for writes and
//   timeouts).
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   imem_* / dmem_*         requester ports: address, wdata, read, write,
//                           byte_enable in; rdata, resp out
//   l2_*                    registered downstream request, rdata/resp back
//   timeout_err             sticky watchdog flag, cleared only by reset
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] imem_address,
    input  logic [DATA_W-1:0] imem_wdata,
    input  logic              imem_read,
    input  logic              imem_write,
    input  logic [1:0]        imem_byte_enable,
    output logic [DATA_W-1:0] imem_rdata,
    output logic              imem_resp,
    input  logic [ADDR_W-1:0] dmem_address,
    input  logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [1:0]        dmem_byte_enable,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_resp,
    output logic [ADDR_W-1:0] l2_address,
    output logic [DATA_W-1:0] l2_wdata,
    output logic              l2_read,
    output logic              l2_write,
    output logic [1:0]        l2_byte_enable,
    input  logic [DATA_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    state_t            state, next_state;
    logic              grant_d;     // 1 = data port owns the current transaction
    logic              last_d;      // round-robin history: 1 = data won last contention
    logic [CNT_W-1:0]  wd_cnt;

    logic              pend_i, pend_d, sel_d, timed_out;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_wr;
    logic [1:0]        req_be;
    logic [DATA_W-1:0] ret_data;

    assign pend_i = imem_read | imem_write;
    assign pend_d = dmem_read | dmem_write;
    // Under contention, the port that did not win last time gets the grant.
    assign sel_d  = pend_d & (~pend_i | ~last_d);

    assign req_addr  = sel_d ? dmem_address : imem_address;
    assign req_wdata = sel_d ? dmem_wdata   : imem_wdata;
    assign req_wr    = sel_d ? dmem_write   : imem_write;
    assign req_be    = sel_d ? dmem_byte_enable : imem_byte_enable;

    assign timed_out = (TIMEOUT != 0) && (wd_cnt >= TO_VAL);
    // Writes and watchdog expiries hand back zero.
    assign ret_data  = (l2_resp && !l2_write) ? l2_rdata : '0;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pend_i || pend_d)     next_state = BUSY;
            BUSY:    if (l2_resp || timed_out) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: the completion pulse lives exactly in RESP.
    always_comb begin
        imem_resp = 1'b0;
        dmem_resp = 1'b0;
        if (state == RESP) begin
            imem_resp = ~grant_d;
            dmem_resp = grant_d;
        end
    end

    // Datapath: latched request, returned data, watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_d        <= 1'b0;
            last_d         <= 1'b0;
            wd_cnt         <= '0;
            l2_address     <= '0;
            l2_wdata       <= '0;
            l2_read        <= 1'b0;
            l2_write       <= 1'b0;
            l2_byte_enable <= 2'b00;
            imem_rdata     <= '0;
            dmem_rdata     <= '0;
            timeout_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_i || pend_d) begin
                        grant_d        <= sel_d;
                        if (pend_i && pend_d) last_d <= sel_d;
                        wd_cnt         <= '0;
                        l2_address     <= req_addr;
                        l2_wdata       <= req_wdata;
                        // Write wins when both strobes are up; reads fetch the full word.
                        l2_write       <= req_wr;
                        l2_read        <= ~req_wr;
                        l2_byte_enable <= req_wr ? req_be : 2'b11;
                    end
                end
                BUSY: begin
                    if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
                    if (l2_resp || timed_out) begin
                        l2_read  <= 1'b0;
                        l2_write <= 1'b0;
                        if (!l2_resp) timeout_err <= 1'b1;
                        if (grant_d) dmem_rdata <= ret_data;
                        else         imem_rdata <= ret_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT=8). A table of single
// transactions is replayed in a loop; hand-written sequences cover
// round-robin, requester drop mid-BUSY, watchdog and reset mid-BUSY.
// Expected responses go into a scoreboard queue and are popped whenever the
// DUT raises a resp pulse.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] imem_address, imem_wdata, imem_rdata;
    logic        imem_read, imem_write, imem_resp;
    logic [1:0]  imem_byte_enable;
    logic [15:0] dmem_address, dmem_wdata, dmem_rdata;
    logic        dmem_read, dmem_write, dmem_resp;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] l2_address, l2_wdata, l2_rdata;
    logic        l2_read, l2_write, l2_resp;
    logic [1:0]  l2_byte_enable;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_d;
        logic [15:0] rdata;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        is_d, rd, wr;
        logic [1:0]  be;
        logic [15:0] addr, wdata, l2d;
        logic        exp_rd, exp_wr;
        logic [1:0]  exp_be;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t tbl[6];

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_address(imem_address), .imem_wdata(imem_wdata),
        .imem_read(imem_read), .imem_write(imem_write),
        .imem_byte_enable(imem_byte_enable),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_byte_enable(dmem_byte_enable),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .l2_address(l2_address), .l2_wdata(l2_wdata),
        .l2_read(l2_read), .l2_write(l2_write),
        .l2_byte_enable(l2_byte_enable),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ports();
        imem_read = 0; imem_write = 0; imem_address = 0; imem_wdata = 0; imem_byte_enable = 0;
        dmem_read = 0; dmem_write = 0; dmem_address = 0; dmem_wdata = 0; dmem_byte_enable = 0;
    endtask

    // Scoreboard: every resp pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (imem_resp || dmem_resp) begin
            if (imem_resp && dmem_resp) begin
                errors++; checks++;
                $display("FAIL sb_both_resp: got both resp high expected one");
            end else if (sb.size() == 0) begin
                errors++; checks++;
                $display("FAIL sb_unexpected: got resp i=%b d=%b expected none", imem_resp, dmem_resp);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_port", 32'(dmem_resp), 32'(e.is_d));
                chk("sb_rdata", dmem_resp ? 32'(dmem_rdata) : 32'(imem_rdata), 32'(e.rdata));
            end
        end
    end

    initial begin
        //          is_d rd   wr   be     addr     wdata    l2d      e_rd e_wr e_be   e_rdata
        tbl[0] = '{1'b1,1'b1,1'b0,2'b11,16'h1234,16'h0000,16'hBEEF,1'b1,1'b0,2'b11,16'hBEEF};
        tbl[1] = '{1'b0,1'b1,1'b0,2'b01,16'h3000,16'h0000,16'h1357,1'b1,1'b0,2'b11,16'h1357};
        tbl[2] = '{1'b1,1'b0,1'b1,2'b10,16'h4444,16'hAB00,16'hFFFF,1'b0,1'b1,2'b10,16'h0000};
        tbl[3] = '{1'b0,1'b1,1'b1,2'b01,16'h5555,16'h00CD,16'h9999,1'b0,1'b1,2'b01,16'h0000};
        tbl[4] = '{1'b1,1'b1,1'b0,2'b00,16'h6666,16'h0000,16'hC0DE,1'b1,1'b0,2'b11,16'hC0DE};
        tbl[5] = '{1'b0,1'b1,1'b0,2'b10,16'h7777,16'h0000,16'h5A5A,1'b1,1'b0,2'b11,16'h5A5A};

        clear_ports();
        l2_rdata = 16'hDEAD; l2_resp = 0;
        rst_n = 0;
        step(); step();
        rst_n = 1;

        // Reset state
        chk("rst_l2_read", 32'(l2_read), 0);
        chk("rst_l2_write", 32'(l2_write), 0);
        chk("rst_l2_addr", 32'(l2_address), 0);
        chk("rst_l2_be", 32'(l2_byte_enable), 0);
        chk("rst_resp", 32'({imem_resp, dmem_resp}), 0);
        chk("rst_rdata", 32'({imem_rdata, dmem_rdata}), 0);
        chk("rst_timeout", 32'(timeout_err), 0);

        // Table: request at cycle 0, strobe at 1, l2_resp at 3, resp at 4.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].is_d) begin
                dmem_read = tbl[i].rd; dmem_write = tbl[i].wr; dmem_byte_enable = tbl[i].be;
                dmem_address = tbl[i].addr; dmem_wdata = tbl[i].wdata;
            end else begin
                imem_read = tbl[i].rd; imem_write = tbl[i].wr; imem_byte_enable = tbl[i].be;
                imem_address = tbl[i].addr; imem_wdata = tbl[i].wdata;
            end
            step();
            chk("v_l2_read", 32'(l2_read), 32'(tbl[i].exp_rd));
            chk("v_l2_write", 32'(l2_write), 32'(tbl[i].exp_wr));
            chk("v_l2_be", 32'(l2_byte_enable), 32'(tbl[i].exp_be));
            chk("v_l2_addr", 32'(l2_address), 32'(tbl[i].addr));
            chk("v_l2_wdata", 32'(l2_wdata), 32'(tbl[i].wdata));
            sb.push_back('{tbl[i].is_d, tbl[i].exp_rdata});
            step(); step();
            chk("v_l2_held", 32'({l2_read, l2_write}), 32'({tbl[i].exp_rd, tbl[i].exp_wr}));
            l2_rdata = tbl[i].l2d; l2_resp = 1;
            step();
            l2_resp = 0; l2_rdata = 16'hDEAD;
            chk("v_resp", 32'(tbl[i].is_d ? dmem_resp : imem_resp), 1);
            chk("v_strobe_drop", 32'({l2_read, l2_write}), 0);
            clear_ports();
            step();
            chk("v_resp_once", 32'({imem_resp, dmem_resp}), 0);
        end

        // Watchdog: dmem rdata is 0xC0DE from the table, must become 0.
        dmem_read = 1; dmem_address = 16'h0BAD;
        sb.push_back('{1'b1, 16'h0000});
        step();                 // cycle 1
        repeat (8) step();      // cycle 9
        chk("to_no_resp_c9", 32'(dmem_resp), 0);
        chk("to_flag_c9", 32'(timeout_err), 0);
        chk("to_read_c9", 32'(l2_read), 1);
        step();                 // cycle 10
        chk("to_resp_c10", 32'(dmem_resp), 1);
        chk("to_rdata", 32'(dmem_rdata), 0);
        chk("to_flag", 32'(timeout_err), 1);
        chk("to_strobe_drop", 32'(l2_read), 0);
        clear_ports();
        step(); step();
        chk("to_sticky", 32'(timeout_err), 1);

        // Requester drops mid-BUSY; also a stray l2_resp in IDLE is ignored.
        l2_resp = 1; step(); l2_resp = 0;
        imem_read = 1; imem_address = 16'h0042;
        step();
        imem_read = 0;
        sb.push_back('{1'b0, 16'h7777});
        step();
        l2_rdata = 16'h7777; l2_resp = 1;
        step();
        l2_resp = 0;
        chk("drop_resp", 32'(imem_resp), 1);
        step();
        chk("drop_no_reserve", 32'({imem_resp, l2_read}), 0);
        chk("to_sticky2", 32'(timeout_err), 1);

        // Round-robin after reset: D, I, D, I with both held.
        rst_n = 0; step(); rst_n = 1;
        chk("rst_clears_to", 32'(timeout_err), 0);
        imem_read = 1; imem_address = 16'h0100;
        dmem_read = 1; dmem_address = 16'h0200;
        step();
        for (int k = 0; k < 4; k++) begin
            logic ed;
            ed = (k % 2 == 0);
            chk("rr_addr", 32'(l2_address), ed ? 32'h200 : 32'h100);
            sb.push_back('{ed, 16'(16'hA000 + k)});
            l2_rdata = 16'(16'hA000 + k); l2_resp = 1;
            step();
            l2_resp = 0;
            chk("rr_resp", 32'({imem_resp, dmem_resp}), ed ? 32'b01 : 32'b10);
            if (k == 3) clear_ports();
            step();
            step();
        end
        chk("rr_idle", 32'({l2_read, l2_write}), 0);

        // Reset mid-BUSY, then stray l2_resp.
        imem_read = 1; imem_address = 16'h0F0F;
        step();
        chk("rb_busy", 32'(l2_read), 1);
        rst_n = 0;
        step();
        rst_n = 1;
        clear_ports();
        chk("rb_l2_read", 32'(l2_read), 0);
        chk("rb_l2_addr", 32'(l2_address), 0);
        chk("rb_rdata", 32'({imem_rdata, dmem_rdata}), 0);
        l2_rdata = 16'h1111; l2_resp = 1;
        step();
        l2_resp = 0;
        chk("rb_no_resp", 32'({imem_resp, dmem_resp}), 0);
        step();
        chk("rb_no_resp2", 32'({imem_resp, dmem_resp, l2_read, l2_write}), 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
